// File: rtl/joy_socd.sv
// joy_socd: per-player SOCD cleaner for digital joysticks. Each raw bit is
// synchronised and optionally debounced; then opposing directions are resolved.
// Ports:
//   clk              system clock, all state on the rising edge
//   reset_n          asynchronous active-low reset
//   mode[1:0]        00/11 last-wins, 01 neutral, 10 first-wins
//   fourway          1 = keep only the most recently pressed axis
//   joy_in[4P-1:0]   raw {U,D,L,R} per player, asynchronous, active-high
//   joy_out[4P-1:0]  resolved {U,D,L,R} per player, registered
module joy_socd #(
    parameter int PLAYERS  = 2,
    parameter int DEBOUNCE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 fourway,
    input  logic [4*PLAYERS-1:0] joy_in,
    output logic [4*PLAYERS-1:0] joy_out
);
    localparam int W = 4 * PLAYERS;
    localparam logic [1:0] MODE_NEUTRAL = 2'b01;
    localparam logic [1:0] MODE_FIRST   = 2'b10;

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] deb;
    logic [W-1:0] prev_q;
    logic [W-1:0] press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= joy_in;
            sync2_q <= sync1_q;
            prev_q  <= deb;
        end
    end

    assign press = deb & ~prev_q;

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign deb = sync2_q;
        end else begin : g_debounce
            localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE - 1);
            logic [W-1:0]       deb_q;
            logic [W-1:0]       deb_d;
            logic [W-1:0][15:0] cnt_q;
            logic [W-1:0][15:0] cnt_d;

            // Counter runs only while the synced bit disagrees; the Nth
            // consecutive disagreeing cycle flips the accepted value.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                for (int i = 0; i < W; i++) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            deb_d[i] = ~deb_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q <= '0;
                    cnt_q <= '0;
                end else begin
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    // bits = {high, low} = {L,R} or {U,D}; last_hi = high direction pressed
    // most recently; tie = both arrived together with no later single press.
    function automatic logic [1:0] resolve_axis(
        input logic [1:0] bits,
        input logic       last_hi,
        input logic       tie,
        input logic [1:0] m
    );
        logic [1:0] r;
        r = bits;
        if (bits == 2'b11) begin
            if (tie || m == MODE_NEUTRAL) begin
                r = 2'b00;
            end else if (m == MODE_FIRST) begin
                r = last_hi ? 2'b01 : 2'b10;
            end else begin
                r = last_hi ? 2'b10 : 2'b01;
            end
        end
        return r;
    endfunction

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [3:0] d;
        logic [3:0] pe;
        logic [1:0] h_res;
        logic [1:0] v_res;
        logic [3:0] out_d;
        logic [3:0] out_q;
        logic       h_ev;
        logic       v_ev;
        logic       last_h_q, last_h_d;
        logic       last_v_q, last_v_d;
        logic       tie_h_q, tie_h_d;
        logic       tie_v_q, tie_v_d;
        logic       axis_q, axis_d;

        assign d    = deb[4*p +: 4];
        assign pe   = press[4*p +: 4];
        assign h_ev = |pe[1:0];
        assign v_ev = |pe[3:2];

        // Resolution uses the next-state history so a press is honoured
        // on the same edge its event is seen.
        always_comb begin
            last_h_d = last_h_q;
            tie_h_d  = tie_h_q;
            case (pe[1:0])
                2'b10: begin last_h_d = 1'b1; tie_h_d = 1'b0; end
                2'b01: begin last_h_d = 1'b0; tie_h_d = 1'b0; end
                2'b11: tie_h_d = 1'b1;
                default: ;
            endcase

            last_v_d = last_v_q;
            tie_v_d  = tie_v_q;
            case (pe[3:2])
                2'b10: begin last_v_d = 1'b1; tie_v_d = 1'b0; end
                2'b01: begin last_v_d = 1'b0; tie_v_d = 1'b0; end
                2'b11: tie_v_d = 1'b1;
                default: ;
            endcase

            axis_d = axis_q;
            if (h_ev && !v_ev) begin
                axis_d = 1'b0;
            end else if (v_ev && !h_ev) begin
                axis_d = 1'b1;
            end

            h_res = resolve_axis(d[1:0], last_h_d, tie_h_d, mode);
            v_res = resolve_axis(d[3:2], last_v_d, tie_v_d, mode);

            out_d = {v_res, h_res};
            if (fourway && (|h_res) && (|v_res)) begin
                out_d = axis_d ? {v_res, 2'b00} : {2'b00, h_res};
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                last_h_q <= 1'b0;
                last_v_q <= 1'b0;
                tie_h_q  <= 1'b0;
                tie_v_q  <= 1'b0;
                axis_q   <= 1'b0;
                out_q    <= '0;
            end else begin
                last_h_q <= last_h_d;
                last_v_q <= last_v_d;
                tie_h_q  <= tie_h_d;
                tie_v_q  <= tie_v_d;
                axis_q   <= axis_d;
                out_q    <= out_d;
            end
        end

        assign joy_out[4*p +: 4] = out_q;
    end

endmodule

// File: tb/tb_joy_socd.sv
// tb_joy_socd: scoreboard bench for joy_socd, two instances (no debounce and
// debounce of 4) driven by the same inputs and checked against a model.
module tb_joy_socd;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       fourway;
    logic [7:0] joy_in;
    logic [7:0] joy0;
    logic [7:0] joy4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic [7:0] m_s1[2];
    logic [7:0] m_s2[2];
    logic [7:0] m_deb[2];
    logic [7:0] m_prev[2];
    int         m_cnt[2][8];
    bit         m_lh[2][2];
    bit         m_lv[2][2];
    bit         m_uh[2][2];
    bit         m_uv[2][2];
    bit         m_ax[2][2];

    joy_socd #(.PLAYERS(2), .DEBOUNCE(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .mode(mode), .fourway(fourway),
        .joy_in(joy_in), .joy_out(joy0)
    );

    joy_socd #(.PLAYERS(2), .DEBOUNCE(4)) dut4 (
        .clk(clk), .reset_n(rst_n), .mode(mode), .fourway(fourway),
        .joy_in(joy_in), .joy_out(joy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k]   = '0;
            m_s2[k]   = '0;
            m_deb[k]  = '0;
            m_prev[k] = '0;
            for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_lh[k][p] = 1'b0;
                m_lv[k][p] = 1'b0;
                m_uh[k][p] = 1'b0;
                m_uv[k][p] = 1'b0;
                m_ax[k][p] = 1'b0;
            end
        end
    endtask

    // One axis: hi/lo held, phi/plo newly pressed; last=1 means hi newest.
    task automatic ax_step(input bit hi, input bit lo, input bit phi,
                           input bit plo, input logic [1:0] md,
                           input bit last_in, input bit unres_in,
                           output bit last_o, output bit unres_o,
                           output logic [1:0] o);
        last_o  = last_in;
        unres_o = unres_in;
        if (phi && plo) begin
            unres_o = 1'b1;
        end else if (phi) begin
            last_o  = 1'b1;
            unres_o = 1'b0;
        end else if (plo) begin
            last_o  = 1'b0;
            unres_o = 1'b0;
        end
        if (!(hi && lo)) o = {hi, lo};
        else if (unres_o) o = 2'b00;
        else begin
            case (md)
                2'b01:   o = 2'b00;
                2'b10:   o = last_o ? 2'b01 : 2'b10;
                default: o = last_o ? 2'b10 : 2'b01;
            endcase
        end
    endtask

    task automatic model_step(input int k, input int n,
                              output logic [7:0] e);
        logic [7:0] cur;
        logic [7:0] pr;
        logic [1:0] h;
        logic [1:0] v;
        bit         lo_;
        bit         uo_;
        bit         hev;
        bit         vev;
        cur = (n == 0) ? m_s2[k] : m_deb[k];
        pr  = cur & ~m_prev[k];
        e   = '0;
        for (int p = 0; p < 2; p++) begin
            ax_step(cur[4*p+1], cur[4*p], pr[4*p+1], pr[4*p], mode,
                    m_lh[k][p], m_uh[k][p], lo_, uo_, h);
            m_lh[k][p] = lo_;
            m_uh[k][p] = uo_;
            ax_step(cur[4*p+3], cur[4*p+2], pr[4*p+3], pr[4*p+2], mode,
                    m_lv[k][p], m_uv[k][p], lo_, uo_, v);
            m_lv[k][p] = lo_;
            m_uv[k][p] = uo_;
            hev = pr[4*p+1] | pr[4*p];
            vev = pr[4*p+3] | pr[4*p+2];
            if (hev && !vev) m_ax[k][p] = 1'b0;
            else if (vev && !hev) m_ax[k][p] = 1'b1;
            e[4*p +: 4] = {v, h};
            if (fourway && h != 2'b00 && v != 2'b00)
                e[4*p +: 4] = m_ax[k][p] ? {v, 2'b00} : {2'b00, h};
        end
        m_prev[k] = cur;
        if (n > 0) begin
            for (int i = 0; i < 8; i++) begin
                if (m_s2[k][i] != m_deb[k][i]) begin
                    m_cnt[k][i]++;
                    if (m_cnt[k][i] == n) begin
                        m_deb[k][i] = ~m_deb[k][i];
                        m_cnt[k][i] = 0;
                    end
                end else begin
                    m_cnt[k][i] = 0;
                end
            end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = joy_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] e;
        if (!rst_n) begin
            model_reset();
            q0.delete();
            q1.delete();
            q0.push_back(8'h00);
            q1.push_back(8'h00);
        end else begin
            model_step(0, 0, e);
            q0.push_back(e);
            model_step(1, 4, e);
            q1.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (q0.size() != 0) chk("dut0_out", joy0, q0.pop_front());
        if (q1.size() != 0) chk("dut4_out", joy4, q1.pop_front());
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rl_seq(input logic [1:0] md, input logic [1:0] e13);
        joy_in = '0;
        mode   = md;
        step(4);
        joy_in[0] = 1'b1;
        step(2);
        chk("rl_t2", {6'b0, joy0[1:0]}, 8'b00);
        step(1);
        chk("rl_t3", {6'b0, joy0[1:0]}, 8'b01);
        step(7);
        joy_in[1] = 1'b1;
        step(2);
        chk("rl_t12", {6'b0, joy0[1:0]}, 8'b01);
        step(1);
        chk("rl_t13", {6'b0, joy0[1:0]}, {6'b0, e13});
        joy_in[1] = 1'b0;
        step(3);
        chk("rl_rel", {6'b0, joy0[1:0]}, 8'b01);
        joy_in = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 2'b00;
        fourway = 1'b0;
        joy_in  = '0;
        step(3);
        chk("reset0", joy0, 8'h00);
        chk("reset4", joy4, 8'h00);
        rst_n = 1'b1;
        step(4);

        rl_seq(2'b00, 2'b10);
        rl_seq(2'b01, 2'b00);
        rl_seq(2'b10, 2'b01);

        mode = 2'b00;
        step(4);
        joy_in[1:0] = 2'b11;
        step(3);
        chk("tie_both", {6'b0, joy0[1:0]}, 8'b00);
        joy_in[1] = 1'b0;
        step(3);
        chk("tie_relL", {6'b0, joy0[1:0]}, 8'b01);
        joy_in[1] = 1'b1;
        step(3);
        chk("tie_repL", {6'b0, joy0[1:0]}, 8'b10);

        joy_in  = '0;
        fourway = 1'b1;
        step(4);
        joy_in[7] = 1'b1;
        step(3);
        chk("4way_U", {4'b0, joy0[7:4]}, 8'b1000);
        joy_in[4] = 1'b1;
        step(3);
        chk("4way_R", {4'b0, joy0[7:4]}, 8'b0001);
        fourway = 1'b0;
        step(1);
        chk("8way_UR", {4'b0, joy0[7:4]}, 8'b1001);

        joy_in = '0;
        step(12);
        joy_in[2] = 1'b1;
        step(3);
        joy_in[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("deb_glitch", {7'b0, joy4[2]}, 8'd0);
        end
        joy_in[2] = 1'b1;
        step(6);
        chk("deb_e6", {7'b0, joy4[2]}, 8'd0);
        joy_in[2] = 1'b0;
        step(1);
        chk("deb_e7", {7'b0, joy4[2]}, 8'd1);

        joy_in = 8'h8B;
        step(12);
        rst_n = 1'b0;
        #1;
        chk("rst_imm0", joy0, 8'h00);
        chk("rst_imm4", joy4, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("rst_e2", joy0, 8'h00);
        step(1);
        chk("rst_e3", joy0, 8'h88);
        step(3);
        chk("rst4_e6", joy4, 8'h00);
        step(1);
        chk("rst4_e7", joy4, 8'h88);

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 7) == 0) joy_in[i] = ~joy_in[i];
            if ($urandom_range(0, 63) == 0)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) fourway = ~fourway;
            if (c == 400) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(1);
        end

        joy_in = '0;
        step(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
